// File: rtl/ro_count_sampler.sv
// Ring-oscillator counter controller: clear, timed enable, settle, stable capture, valid/ready out.
// result_valid rises CLR_CYCLES+window+SETTLE_CYCLES+2 clk cycles after the start cycle (stable input).
module ro_count_sampler #(
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_MAX    = 8,
  parameter int WIN_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic [63:0]      cnt_val,
  output logic             ro_en,
  output logic             cnt_rst,
  output logic [63:0]      result,
  output logic             result_err,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int AW = $clog2(STABLE_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [AW-1:0]    attempt_q, attempt_d;

  logic [63:0] s1_q, s1_d;
  logic [63:0] s2_q, s2_d;
  logic [63:0] s3_q, s3_d;

  logic        ro_en_q, ro_en_d;
  logic        cnt_rst_q, cnt_rst_d;
  logic        busy_q, busy_d;
  logic [63:0] result_q, result_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;

  logic        timer_last;
  logic        same;
  logic        give_up;

  assign timer_last = (timer_q <= WIN_W'(1));
  assign same       = (s2_q == s3_q);
  assign give_up    = (attempt_q >= AW'(STABLE_MAX - 1));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    win_d     = win_q;
    attempt_d = attempt_q;
    ro_en_d   = ro_en_q;
    cnt_rst_d = cnt_rst_q;
    busy_d    = busy_q;
    result_d  = result_q;
    err_d     = err_q;
    valid_d   = valid_q;
    s1_d      = cnt_val;
    s2_d      = s1_q;
    s3_d      = s2_q;

    unique case (state_q)
      IDLE: begin
        ro_en_d   = 1'b0;
        cnt_rst_d = 1'b1;
        if (start) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          timer_d = WIN_W'(CLR_CYCLES);
          // A zero window still opens the oscillator for one cycle
          win_d   = (window_cycles == '0) ?
                    WIN_W'(1) : window_cycles;
        end
      end
      CLEAR: begin
        if (timer_last) begin
          state_d   = MEASURE;
          cnt_rst_d = 1'b0;
          ro_en_d   = 1'b1;
          timer_d   = win_q;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      MEASURE: begin
        if (timer_last) begin
          state_d = SETTLE;
          ro_en_d = 1'b0;
          timer_d = WIN_W'(SETTLE_CYCLES);
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      SETTLE: begin
        if (timer_last) begin
          state_d   = CAPTURE;
          attempt_d = '0;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      CAPTURE: begin
        if (same || give_up) begin
          state_d  = HOLD;
          result_d = s2_q;
          err_d    = ~same;
          valid_d  = 1'b1;
        end else begin
          attempt_d = attempt_q + AW'(1);
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          cnt_rst_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        ro_en_d   = 1'b0;
        cnt_rst_d = 1'b1;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      win_q     <= '0;
      attempt_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      ro_en_q   <= 1'b0;
      cnt_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      attempt_q <= attempt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      ro_en_q   <= ro_en_d;
      cnt_rst_q <= cnt_rst_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign ro_en        = ro_en_q;
  assign cnt_rst      = cnt_rst_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_err   = err_q;
  assign result_valid = valid_q;

endmodule
